// File: rtl/uart_rx_if.sv
// Serial receive interface: line input plus received-byte strobes.
//   rx        : serial line into the receiver (idle high)
//   data      : received byte, bit 0 = first data bit on the line
//   valid     : one-cycle strobe, data holds a good frame
//   frame_err : one-cycle strobe, stop bit sampled low
//   busy      : receiver is inside a frame
// master = line driver / byte consumer side, slave = the receiver.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  modport master (
    output rx,
    input  data,
    input  valid,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  rx,
    output data,
    output valid,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with CLKS_PER_BIT oversampling and a 3-sample majority vote
// around each bit centre.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : uart_rx_if slave (rx in; data, valid, frame_err, busy out)
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam int unsigned TW  = $clog2(CLKS_PER_BIT);
  localparam int unsigned Mid = CLKS_PER_BIT / 2;

  localparam logic [TW-1:0] TSamp0 = TW'(Mid - 1);
  localparam logic [TW-1:0] TSamp1 = TW'(Mid);
  localparam logic [TW-1:0] TVote  = TW'(Mid + 1);
  localparam logic [TW-1:0] TLast  = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rxs_prev_q, rxs_prev_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [2:0]             idx_q, idx_d;
  logic [1:0]             samp_q, samp_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;

  logic          rxs;
  logic          vote;
  logic          at_vote;
  logic          at_end;
  logic [TW-1:0] timer_inc;

  assign rxs       = sync_q[SYNC_STAGES-1];
  assign timer_inc = timer_q + 1'b1;
  assign at_vote   = (timer_q == TVote);
  assign at_end    = (timer_q == TLast);
  // Third sample is the live value at MID+1, so the vote is ready that same cycle.
  assign vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);

  always_comb begin
    state_d    = state_q;
    sync_d     = {sync_q[SYNC_STAGES-2:0], bus.rx};
    rxs_prev_d = rxs;
    timer_d    = timer_q;
    idx_d      = idx_q;
    samp_d     = samp_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;

    if (timer_q == TSamp0) samp_d[0] = rxs;
    if (timer_q == TSamp1) samp_d[1] = rxs;

    case (state_q)
      StIdle: begin
        // Edge-triggered: a line held low (break) never retriggers.
        if (rxs_prev_q && !rxs) begin
          timer_d = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        timer_d = timer_inc;
        if (at_vote && vote) begin
          state_d = StIdle;
        end else if (at_end) begin
          timer_d = '0;
          idx_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        timer_d = timer_inc;
        if (at_vote) shift_d[idx_q] = vote;
        if (at_end) begin
          timer_d = '0;
          if (idx_q == 3'd7) state_d = StStop;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      StStop: begin
        timer_d = timer_inc;
        // Leave at mid stop bit so an immediately following start edge is seen.
        if (at_vote) begin
          if (vote) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      sync_q     <= '1;
      rxs_prev_q <= 1'b1;
      timer_q    <= '0;
      idx_q      <= '0;
      samp_q     <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      rxs_prev_q <= rxs_prev_d;
      timer_q    <= timer_d;
      idx_q      <= idx_d;
      samp_q     <= samp_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state_q != StIdle);

endmodule
